// File: rtl/data_mem_if.sv
// Data-port handshake between the CPU control FSM (master) and the memory responder (slave).
interface data_mem_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [3:0]  BE;
  logic [31:0] WData;
  logic        Ready;
  logic        Done;
  logic [31:0] RData;
  logic        Err;

  modport master (
    output MemRead, MemWrite, Addr, BE, WData,
    input  Ready, Done, RData, Err
  );

  modport slave (
    input  MemRead, MemWrite, Addr, BE, WData,
    output Ready, Done, RData, Err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: accepts one word request at a time, waits LATENCY cycles,
// then performs a byte-masked read or write and pulses Done (with Err on bad requests).
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  data_mem_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   idx_q;
  logic [3:0]          be_q;
  logic [31:0]         wdata_q;
  logic                wr_q;
  logic                done_q;
  logic                err_q;
  logic [31:0]         rdata_q;

  logic [31:0]         mem [2**ADDR_W];

  logic                req;
  logic                bad;
  logic                access;
  logic [ADDR_W-1:0]   acc_idx;
  logic [3:0]          acc_be;
  logic [31:0]         acc_wdata;
  logic                acc_wr;
  logic [31:0]         mask;

  assign req = bus.MemRead | bus.MemWrite;
  assign bad = (bus.MemRead & bus.MemWrite)
             | (bus.Addr[1:0] != 2'b00)
             | ((bus.Addr >> (ADDR_W + 2)) != '0)
             | (bus.BE == 4'b0000);

  // With LATENCY=0 the access happens on the accept edge, so it must use the live inputs.
  always_comb begin
    access    = 1'b0;
    acc_idx   = idx_q;
    acc_be    = be_q;
    acc_wdata = wdata_q;
    acc_wr    = wr_q;
    if (state == ST_IDLE) begin
      acc_idx   = bus.Addr[ADDR_W+1:2];
      acc_be    = bus.BE;
      acc_wdata = bus.WData;
      acc_wr    = bus.MemWrite;
      access    = req & ~bad & (LATENCY == 0);
    end else if (state == ST_WAIT) begin
      access    = (cnt == 4'd1);
    end
  end

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < 4; i++)
      mask[8*i +: 8] = {8{acc_be[i]}};
  end

  // Memory has no reset; a write is only dropped when reset is sampled on the commit edge.
  always_ff @(posedge CLK) begin
    if (RSTn && access && acc_wr) begin
      for (int unsigned i = 0; i < 4; i++)
        if (acc_be[i])
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (req) begin
            idx_q   <= bus.Addr[ADDR_W+1:2];
            be_q    <= bus.BE;
            wdata_q <= bus.WData;
            wr_q    <= bus.MemWrite;
            if (bad) begin
              state  <= ST_RESP;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else if (LATENCY == 0) begin
              state  <= ST_RESP;
              done_q <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= 4'(LATENCY);
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state  <= ST_RESP;
            done_q <= 1'b1;
          end
        end
        ST_RESP: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (access && !acc_wr)
        rdata_q <= mem[acc_idx] & mask;
    end
  end

  assign bus.Ready = RSTn && (state == ST_IDLE);
  assign bus.Done  = done_q;
  assign bus.Err   = err_q;
  assign bus.RData = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder built with LATENCY=2 (dut_a) and one with LATENCY=0 (dut_b).
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rstn_a = 1'b0;
  logic rstn_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_acc = 0;
  int   prev_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_if bus_a ();
  data_mem_if bus_b ();

  data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut_a (.CLK(clk), .RSTn(rstn_a), .bus(bus_a));
  data_mem_responder #(.ADDR_W(10), .LATENCY(0)) dut_b (.CLK(clk), .RSTn(rstn_b), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    if (!sel) begin
      bus_a.MemRead = rd; bus_a.MemWrite = wr; bus_a.Addr = addr; bus_a.BE = be; bus_a.WData = wd;
    end else begin
      bus_b.MemRead = rd; bus_b.MemWrite = wr; bus_b.Addr = addr; bus_b.BE = be; bus_b.WData = wd;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? bus_b.Ready : bus_a.Ready;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? bus_b.Done : bus_a.Done;
  endfunction

  // Present one request in the next Ready cycle (cycle 0) and time its Done pulse.
  task automatic req(input bit sel, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                     output int dcyc, output logic [31:0] rdat, output logic errv);
    int n;
    dcyc = -1;
    rdat = '0;
    errv = 1'b0;
    n = 0;
    @(negedge clk);
    while (!get_ready(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!get_ready(sel)) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    prev_acc = last_acc;
    last_acc = cyc;
    drive(sel, rd, wr, addr, be, wd);
    @(posedge clk);
    #1 drive(sel, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (get_done(sel)) begin
        dcyc = k;
        rdat = sel ? bus_b.RData : bus_a.RData;
        errv = sel ? bus_b.Err : bus_a.Err;
        break;
      end
    end
    if (dcyc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic op(input string tag, input bit sel, input logic rd, input logic wr,
                    input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                    input int exp_cyc, input logic exp_err, input logic [31:0] exp_rdata);
    int d;
    logic [31:0] r;
    logic e;
    req(sel, rd, wr, addr, be, wd, d, r, e);
    if (d >= 0) begin
      chk({tag, "_cyc"}, 32'(d), 32'(exp_cyc));
      chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
      chk({tag, "_rdata"}, r, exp_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_ready_a", {31'd0, bus_a.Ready}, 32'd0);
    chk("rst_done_a",  {31'd0, bus_a.Done},  32'd0);
    chk("rst_err_a",   {31'd0, bus_a.Err},   32'd0);
    chk("rst_rdata_a", bus_a.RData, 32'd0);
    chk("rst_ready_b", {31'd0, bus_b.Ready}, 32'd0);
    rstn_a = 1'b1;
    rstn_b = 1'b1;
    @(negedge clk);
    chk("rel_ready_a", {31'd0, bus_a.Ready}, 32'd1);
    chk("rel_ready_b", {31'd0, bus_b.Ready}, 32'd1);

    // LATENCY=2: full write, read back, partial write and masked reads
    op("wr10",    1'b0, 1'b0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 3, 1'b0, 32'h0);
    op("rd10",    1'b0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0,        3, 1'b0, 32'hDEADBEEF);
    chk("rd10_gap", 32'(last_acc - prev_acc), 32'd4);
    op("pwr10",   1'b0, 1'b0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, 3, 1'b0, 32'hDEADBEEF);
    op("rd10_full", 1'b0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0,      3, 1'b0, 32'hDEAABEEF);
    op("rd10_lo", 1'b0, 1'b1, 1'b0, 32'h10, 4'b0011, 32'h0,        3, 1'b0, 32'h0000BEEF);

    // Error requests: 2-cycle response, RData and memory untouched
    op("err_mis",  1'b0, 1'b0, 1'b1, 32'h12,   4'b1111, 32'h11111111, 1, 1'b1, 32'h0000BEEF);
    op("err_both", 1'b0, 1'b1, 1'b1, 32'h10,   4'b1111, 32'h22222222, 1, 1'b1, 32'h0000BEEF);
    op("err_oor",  1'b0, 1'b1, 1'b0, 32'h1000, 4'b1111, 32'h0,        1, 1'b1, 32'h0000BEEF);
    op("err_be0",  1'b0, 1'b0, 1'b1, 32'h10,   4'b0000, 32'h33333333, 1, 1'b1, 32'h0000BEEF);
    op("rd10_post_err", 1'b0, 1'b1, 1'b0, 32'h10, 4'b1111, 32'h0,     3, 1'b0, 32'hDEAABEEF);

    // Reset during WAIT drops the pending write
    op("wr20",    1'b0, 1'b0, 1'b1, 32'h20, 4'b1111, 32'h0BADF00D, 3, 1'b0, 32'hDEAABEEF);
    @(negedge clk);
    chk("mid_ready_c0", {31'd0, bus_a.Ready}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 32'h20, 4'b1111, 32'h12345678);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("mid_ready_c1", {31'd0, bus_a.Ready}, 32'd0);
    rstn_a = 1'b0;
    @(negedge clk);
    chk("mid_done_rst",  {31'd0, bus_a.Done},  32'd0);
    chk("mid_err_rst",   {31'd0, bus_a.Err},   32'd0);
    chk("mid_ready_rst", {31'd0, bus_a.Ready}, 32'd0);
    chk("mid_rdata_rst", bus_a.RData, 32'd0);
    rstn_a = 1'b1;
    @(negedge clk);
    chk("mid_ready_rel", {31'd0, bus_a.Ready}, 32'd1);
    op("rd20",    1'b0, 1'b1, 1'b0, 32'h20, 4'b1111, 32'h0,        3, 1'b0, 32'h0BADF00D);

    // LATENCY=0: streaming writes then reads, one accept every 2 cycles
    for (int i = 0; i < 8; i++) begin
      op("swr", 1'b1, 1'b0, 1'b1, 32'h40 + 32'(4*i), 4'b1111, 32'hCAFE0000 | 32'(i), 1, 1'b0, 32'h0);
      if (i > 0) chk("swr_gap", 32'(last_acc - prev_acc), 32'd2);
    end
    for (int i = 0; i < 8; i++) begin
      op("srd", 1'b1, 1'b1, 1'b0, 32'h40 + 32'(4*i), 4'b1111, 32'h0, 1, 1'b0, 32'hCAFE0000 | 32'(i));
      chk("srd_gap", 32'(last_acc - prev_acc), 32'd2);
    end
    op("b_rd_mask", 1'b1, 1'b1, 1'b0, 32'h44, 4'b1000, 32'h0, 1, 1'b0, 32'hCA000000);
    @(negedge clk);
    chk("b_ready_c2", {31'd0, bus_b.Ready}, 32'd1);
    op("b_err_mis", 1'b1, 1'b1, 1'b0, 32'h42, 4'b1111, 32'h0, 1, 1'b1, 32'hCA000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
